// File: rtl/sonar_tx_pkg.sv
// Shared types and constants for the sonar frame transmitter.
// Checksum build option: SONAR_TX_CHECKSUM_EN.
package sonar_tx_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'h0,
      CARREGA = 4'h1,
      ENVIA   = 4'h2,
      ESPERA  = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'h5,
      ERRO    = 4'hF
   } state_t;

   localparam logic [6:0] ASCII_ZERO    = 7'h30;
   localparam logic [6:0] ASCII_COMMA   = 7'h2C;
   localparam logic [6:0] ASCII_HASH    = 7'h23;
   localparam logic [6:0] ASCII_INVALID = 7'h3F;

   localparam logic [3:0] LAST_IDX_BASE  = 4'd7;
   localparam logic [3:0] LAST_IDX_CKSUM = 4'd8;

   function automatic logic [6:0] digit_ascii(input logic [3:0] n);
      return (n <= 4'd9) ? ASCII_ZERO + {3'b000, n} : ASCII_INVALID;
   endfunction

   function automatic logic [3:0] digit_val(input logic [3:0] n);
      return (n <= 4'd9) ? n : 4'd0;
   endfunction

endpackage

// File: rtl/bcd_ascii_mux.sv
// Selects the ASCII character for a frame index from the latched operands.
// SONAR_TX_CHECKSUM_EN adds a checksum character before the terminator.
module bcd_ascii_mux
   import sonar_tx_pkg::*;
(
   input  logic [3:0]  indice,
   input  logic [11:0] angulo,
   input  logic [11:0] distancia,
   output logic [6:0]  caractere
);

`ifdef SONAR_TX_CHECKSUM_EN
   logic [5:0] soma;
   logic [6:0] checksum;

   // Invalid nibbles contribute nothing to the sum
   always_comb begin
      soma = {2'b00, digit_val(angulo[11:8])}
           + {2'b00, digit_val(angulo[7:4])}
           + {2'b00, digit_val(angulo[3:0])}
           + {2'b00, digit_val(distancia[11:8])}
           + {2'b00, digit_val(distancia[7:4])}
           + {2'b00, digit_val(distancia[3:0])};
      checksum = ASCII_ZERO + {1'b0, soma % 6'd10};
   end
`endif

   always_comb begin
      caractere = ASCII_HASH;
      case (indice)
         4'd0: caractere = digit_ascii(angulo[11:8]);
         4'd1: caractere = digit_ascii(angulo[7:4]);
         4'd2: caractere = digit_ascii(angulo[3:0]);
         4'd3: caractere = ASCII_COMMA;
         4'd4: caractere = digit_ascii(distancia[11:8]);
         4'd5: caractere = digit_ascii(distancia[7:4]);
         4'd6: caractere = digit_ascii(distancia[3:0]);
`ifdef SONAR_TX_CHECKSUM_EN
         4'd7: caractere = checksum;
`endif
         default: caractere = ASCII_HASH;
      endcase
   end

endmodule

// File: rtl/sonar_frame_tx_ctrl.sv
// Sequences the UART TX to send "AAA,DDD#" with a per-character watchdog.
// SONAR_TX_CHECKSUM_EN inserts a checksum character before '#'.
module sonar_frame_tx_ctrl
   import sonar_tx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic [11:0] angulo,
   input  logic [11:0] distancia,
   input  logic        pronto_serial,
   output logic        partida_serial,
   output logic [6:0]  dados_ascii,
   output logic        ocupado,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado,
   output logic [3:0]  db_indice
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef SONAR_TX_CHECKSUM_EN
   localparam logic [3:0] LAST_IDX = LAST_IDX_CKSUM;
`else
   localparam logic [3:0] LAST_IDX = LAST_IDX_BASE;
`endif

   state_t state, state_n;
   logic [3:0] indice, indice_n;
   logic [11:0] ang_q, ang_n;
   logic [11:0] dist_q, dist_n;
   logic [WD_W-1:0] wd;
   logic wd_exp;
   logic erro_q;
   logic [6:0] dados_q, car_n;

   assign wd_exp = (wd == WD_MAX);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (iniciar) state_n = CARREGA;
         CARREGA: state_n = ENVIA;
         ENVIA:   state_n = ESPERA;
         ESPERA: begin
            // A done pulse on the expiry cycle still counts
            if (pronto_serial)
               state_n = (indice == LAST_IDX) ? FIM : PROXIMO;
            else if (wd_exp)
               state_n = ERRO;
         end
         PROXIMO: state_n = ENVIA;
         FIM:     state_n = IDLE;
         ERRO:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      indice_n = indice;
      ang_n    = ang_q;
      dist_n   = dist_q;
      if (state == CARREGA) begin
         indice_n = 4'd0;
         ang_n    = angulo;
         dist_n   = distancia;
      end else if (state == PROXIMO) begin
         indice_n = indice + 4'd1;
      end
   end

   // Character is looked up from next-cycle values so it lands with ENVIA
   bcd_ascii_mux u_mux (
      .indice    (indice_n),
      .angulo    (ang_n),
      .distancia (dist_n),
      .caractere (car_n)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         indice  <= 4'd0;
         ang_q   <= 12'd0;
         dist_q  <= 12'd0;
         wd      <= '0;
         erro_q  <= 1'b0;
         dados_q <= 7'd0;
      end else begin
         state   <= state_n;
         indice  <= indice_n;
         ang_q   <= ang_n;
         dist_q  <= dist_n;
         wd      <= (state == ESPERA) ? wd + WD_W'(1) : '0;
         if (state == CARREGA)
            erro_q <= 1'b0;
         else if (state_n == ERRO)
            erro_q <= 1'b1;
         if (state_n == IDLE || state_n == CARREGA)
            dados_q <= 7'd0;
         else
            dados_q <= car_n;
      end
   end

   assign partida_serial = (state == ENVIA);
   assign pronto         = (state == FIM);
   assign ocupado        = (state != IDLE);
   assign erro           = erro_q;
   assign dados_ascii    = dados_q;
   assign db_estado      = state;
   assign db_indice      = indice;

endmodule

// File: tb/tb_sonar_frame_tx_ctrl.sv
// Directed bench for sonar_frame_tx_ctrl with a delayed-answer UART model.
// Build with SONAR_TX_CHECKSUM_EN to check the checksum frame.
module tb_sonar_frame_tx_ctrl;

   localparam int TO = 40;
`ifdef SONAR_TX_CHECKSUM_EN
   localparam int NCH = 9;
`else
   localparam int NCH = 8;
`endif

   logic clock = 1'b0;
   logic reset, iniciar, pronto_serial;
   logic [11:0] angulo, distancia;
   logic partida_serial, ocupado, pronto, erro;
   logic [6:0] dados_ascii;
   logic [3:0] db_estado, db_indice;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int uart_limit = 1000;
   int answered = 0;
   int npulses = 0;
   int npronto = 0;
   logic [6:0] chars[$];
   int pcyc[$];

   sonar_frame_tx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clock          (clock),
      .reset          (reset),
      .iniciar        (iniciar),
      .angulo         (angulo),
      .distancia      (distancia),
      .pronto_serial  (pronto_serial),
      .partida_serial (partida_serial),
      .dados_ascii    (dados_ascii),
      .ocupado        (ocupado),
      .pronto         (pronto),
      .erro           (erro),
      .db_estado      (db_estado),
      .db_indice      (db_indice)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (partida_serial) begin
         chars.push_back(dados_ascii);
         pcyc.push_back(cyc);
         npulses++;
      end
      if (pronto) npronto++;
   end

   // UART model: answers each start 20 cycles later, up to uart_limit
   initial begin
      pronto_serial = 1'b0;
      forever begin
         @(negedge clock);
         if (partida_serial && !reset && answered < uart_limit) begin
            answered++;
            repeat (19) @(negedge clock);
            pronto_serial = 1'b1;
            @(negedge clock);
            pronto_serial = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      chars.delete();
      pcyc.delete();
      npulses = 0;
      npronto = 0;
      answered = 0;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      int n = 0;
      while (!pronto && n < maxc) begin
         @(negedge clock);
         n++;
      end
      chk(tag, {31'd0, pronto}, 32'd1);
   endtask

   function automatic logic [31:0] ch(input int i);
      if (i < chars.size()) return {25'd0, chars[i]};
      return 32'hFFFF_FFFF;
   endfunction

   logic [6:0] exp1 [9];
   int t3, n0;
   logic seen;

   initial begin
      exp1 = '{7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33,
`ifdef SONAR_TX_CHECKSUM_EN
               7'h35,
`else
               7'h23,
`endif
               7'h23};
      reset = 1'b1;
      iniciar = 1'b0;
      angulo = 12'h000;
      distancia = 12'h000;
      repeat (2) @(negedge clock);
      chk("rst_estado", {28'd0, db_estado}, 32'h0);
      chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
      chk("rst_partida", {31'd0, partida_serial}, 32'd0);
      chk("rst_pronto", {31'd0, pronto}, 32'd0);
      chk("rst_erro", {31'd0, erro}, 32'd0);
      chk("rst_dados", {25'd0, dados_ascii}, 32'd0);
      chk("rst_indice", {28'd0, db_indice}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Frame 1: basic frame and start latency
      clear_mon();
      angulo = 12'h045;
      distancia = 12'h123;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      chk("f1_carrega", {28'd0, db_estado}, 32'h1);
      @(negedge clock);
      chk("f1_partida", {31'd0, partida_serial}, 32'd1);
      chk("f1_dados0", {25'd0, dados_ascii}, 32'h30);
      wait_done("f1_done", 400);
      chk("f1_npulses", npulses, NCH);
      for (int i = 0; i < NCH; i++)
         chk($sformatf("f1_char%0d", i), ch(i), {25'd0, exp1[i]});
      chk("f1_erro", {31'd0, erro}, 32'd0);
      @(negedge clock);
      chk("f1_idle", {28'd0, db_estado}, 32'h0);
      chk("f1_dados_idle", {25'd0, dados_ascii}, 32'd0);
      chk("f1_npronto", npronto, 1);

      // Frame 2: UART stalls on the 3rd character
      clear_mon();
      uart_limit = 2;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      n0 = 0;
      while (!erro && n0 < 300) begin
         @(negedge clock);
         n0++;
      end
      chk("to_erro", {31'd0, erro}, 32'd1);
      t3 = (pcyc.size() >= 3) ? pcyc[2] : -1000;
      chk("to_latency", cyc - t3, TO + 1);
      chk("to_estado", {28'd0, db_estado}, 32'hF);
      @(negedge clock);
      chk("to_idle", {28'd0, db_estado}, 32'h0);
      chk("to_sticky", {31'd0, erro}, 32'd1);
      chk("to_npronto", npronto, 0);

      // Next frame clears the sticky error
      clear_mon();
      uart_limit = 1000;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      @(negedge clock);
      chk("clr_erro", {31'd0, erro}, 32'd0);
      wait_done("clr_done", 400);
      @(negedge clock);

      // Frame 3: iniciar held, angulo changes mid-frame
      clear_mon();
      angulo = 12'h045;
      iniciar = 1'b1;
      n0 = 0;
      while (pcyc.size() < 2 && n0 < 100) begin
         @(negedge clock);
         n0++;
      end
      angulo = 12'h090;
      wait_done("hold_done", 400);
      chk("hold_c0", ch(0), 32'h30);
      chk("hold_c1", ch(1), 32'h34);
      chk("hold_c2", ch(2), 32'h35);
      clear_mon();
      @(negedge clock);
      chk("hold_idle", {28'd0, db_estado}, 32'h0);
      @(negedge clock);
      chk("hold_carrega", {28'd0, db_estado}, 32'h1);
      iniciar = 1'b0;
      @(negedge clock);
      chk("hold_partida", {31'd0, partida_serial}, 32'd1);
      wait_done("hold2_done", 400);
      chk("hold2_c1", ch(1), 32'h39);
      @(negedge clock);

      // Frame 4: invalid BCD digit
      clear_mon();
      angulo = 12'h045;
      distancia = 12'h1A2;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      wait_done("inv_done", 400);
      chk("inv_c5", ch(5), 32'h3F);
`ifdef SONAR_TX_CHECKSUM_EN
      chk("inv_cksum", ch(7), 32'h32);
`endif
      @(negedge clock);

      // Frame 5: reset while waiting on index 5
      clear_mon();
      distancia = 12'h123;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      n0 = 0;
      while (!(db_estado == 4'h3 && db_indice == 4'd5) && n0 < 400) begin
         @(negedge clock);
         n0++;
      end
      chk("mid_reach", {28'd0, db_indice}, 32'd5);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_estado", {28'd0, db_estado}, 32'h0);
      chk("mid_ocupado", {31'd0, ocupado}, 32'd0);
      chk("mid_partida", {31'd0, partida_serial}, 32'd0);
      chk("mid_dados", {25'd0, dados_ascii}, 32'd0);
      chk("mid_indice", {28'd0, db_indice}, 32'd0);
      chk("mid_erro", {31'd0, erro}, 32'd0);
      n0 = npulses;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (ocupado) seen = 1'b1;
      end
      chk("mid_stray_busy", {31'd0, seen}, 32'd0);
      chk("mid_stray_pulses", npulses - n0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
